// File: rtl/bdd_sbox_pkg.sv
// Shared types and defaults for the dual-rail BDD S-box lookup controller.
package bdd_sbox_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRECH = 2'd1,
    ST_EVAL  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam int PRE_CYCLES_DEF  = 2;
  localparam int EVAL_CYCLES_DEF = 3;

  localparam int                CNT_W   = 4;
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

endpackage

// File: rtl/bdd_phase_cnt.sv
// Phase down-counter: loads a length, counts down to zero without wrapping,
// and flags the last cycle of the phase (count == 1).
module bdd_phase_cnt
  import bdd_sbox_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_ONE;
    end
  end

  assign done = (cnt == CNT_ONE);

endmodule

// File: rtl/bdd_sbox_ctrl.sv
// Precharge/evaluate sequencer for a dual-rail BDD S-box MUX array.
// Define BDD_SBOX_CTRL_RETRY_EN to retry one lookup after a dual-rail violation.
//
// state    | meaning
// IDLE     | waiting for a lookup request (in_ready high)
// PRECH    | all pass gates off, rails precharging
// EVAL     | selects driven from latched data, rails evaluating
// RESP     | result held until the consumer accepts it
module bdd_sbox_ctrl
  import bdd_sbox_pkg::*;
#(
  parameter int N_IN        = 4,
  parameter int N_OUT       = 4,
  parameter int PRE_CYCLES  = PRE_CYCLES_DEF,
  parameter int EVAL_CYCLES = EVAL_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_data,
  output logic [N_IN-1:0]  select,
  output logic [N_IN-1:0]  selectBar,
  output logic             pre,
  input  logic [N_OUT-1:0] u_out,
  input  logic [N_OUT-1:0] c_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] out_data,
  output logic             out_err
);

  localparam logic [CNT_W-1:0] PRE_LD  = CNT_W'(PRE_CYCLES);
  localparam logic [CNT_W-1:0] EVAL_LD = CNT_W'(EVAL_CYCLES);

  state_t           state;
  logic [N_IN-1:0]  data_q;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_dec;
  logic             cnt_done;
  logic             viol;
  logic             retry_now;

  // A slice is broken when both rails agree after evaluation.
  assign viol = |(~(u_out ^ c_out));

`ifdef BDD_SBOX_CTRL_RETRY_EN
  logic retried;
  assign retry_now = viol && !retried;
`else
  assign retry_now = 1'b0;
`endif

  assign cnt_dec = (state == ST_PRECH) || (state == ST_EVAL);

  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    unique case (state)
      ST_IDLE: if (in_valid && in_ready) begin
        cnt_load = 1'b1;
        cnt_val  = PRE_LD;
      end
      ST_PRECH: if (cnt_done) begin
        cnt_load = 1'b1;
        cnt_val  = EVAL_LD;
      end
      ST_EVAL: if (cnt_done) begin
        cnt_load = 1'b1;
        cnt_val  = retry_now ? PRE_LD : '0;
      end
      ST_RESP: if (out_valid && out_ready) begin
        cnt_load = 1'b1;
        cnt_val  = '0;
      end
    endcase
  end

  bdd_phase_cnt u_phase_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .done     (cnt_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      data_q    <= '0;
      pre       <= 1'b0;
      select    <= '0;
      selectBar <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
`ifdef BDD_SBOX_CTRL_RETRY_EN
      retried   <= 1'b0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            data_q   <= in_data;
            in_ready <= 1'b0;
            state    <= ST_PRECH;
`ifdef BDD_SBOX_CTRL_RETRY_EN
            retried  <= 1'b0;
`endif
          end
        end
        ST_PRECH: begin
          if (cnt_done) begin
            pre       <= 1'b1;
            select    <= data_q;
            selectBar <= ~data_q;
            state     <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          if (cnt_done) begin
            pre       <= 1'b0;
            select    <= '0;
            selectBar <= '0;
            if (retry_now) begin
              state   <= ST_PRECH;
`ifdef BDD_SBOX_CTRL_RETRY_EN
              retried <= 1'b1;
`endif
            end else begin
              out_valid <= 1'b1;
              out_data  <= u_out;
              out_err   <= viol;
              state     <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bdd_sbox_ctrl.sv
// Directed testbench for bdd_sbox_ctrl with default parameters.
module tb_bdd_sbox_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] in_data = 4'h0;
  logic [3:0] u_out = 4'h0;
  logic [3:0] c_out = 4'h0;
  logic       in_ready, pre, out_valid, out_err;
  logic [3:0] select, selectBar, out_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bdd_sbox_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .select    (select),
    .selectBar (selectBar),
    .pre       (pre),
    .u_out     (u_out),
    .c_out     (c_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {pre, select, selectBar, out_valid, in_ready}
  function automatic logic [10:0] obs();
    return {pre, select, selectBar, out_valid, in_ready};
  endfunction

  // Expected control vector c cycles after acceptance (no retry).
  function automatic logic [10:0] exp_vec(int c, logic [3:0] d);
    if (c >= 3 && c <= 5) return {1'b1, d, ~d, 1'b0, 1'b0};
    if (c == 6) return {1'b0, 4'h0, 4'h0, 1'b1, 1'b0};
    return 11'b0;
  endfunction

  task automatic wait_ready(input string tag);
    int k = 0;
    while (in_ready !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s wait_ready: in_ready=%b required 1", tag, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_tests++;
    if (obs() !== 11'b0 || {out_data, out_err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_state: ctrl=%b data=%h err=%b required 0", obs(), out_data, out_err);
    end
    rst = 1'b0;
    tick();
    n_tests++;
    if (obs() !== 11'b1) begin
      n_fail++;
      $display("FAIL reset_idle_ready: ctrl=%b required %b", obs(), 11'b1);
    end
  endtask

  task automatic test_nominal();
    wait_ready("nominal");
    in_data = 4'hA; in_valid = 1'b1; u_out = 4'b1010; c_out = 4'b0101; out_ready = 1'b0;
    tick();
    in_valid = 1'b0; in_data = 4'h0;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) tick();
      n_tests++;
      if (obs() !== exp_vec(c, 4'hA)) begin
        n_fail++;
        $display("FAIL nominal_cyc%0d: ctrl=%b required %b", c, obs(), exp_vec(c, 4'hA));
      end
    end
    n_tests++;
    if ({out_data, out_err} !== {4'hA, 1'b0}) begin
      n_fail++;
      $display("FAIL nominal_result: data=%h err=%b required A/0", out_data, out_err);
    end
    // Consumer stalls; new requests and rail changes must not disturb the result.
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_data = 4'h3; u_out = 4'h0; c_out = 4'h0;
      tick();
      n_tests++;
      if (obs() !== exp_vec(6, 4'h0) || {out_data, out_err} !== {4'hA, 1'b0}) begin
        n_fail++;
        $display("FAIL hold_%0d: ctrl=%b data=%h err=%b required %b A/0", k, obs(), out_data, out_err, exp_vec(6, 4'h0));
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_tests++;
    if (obs() !== 11'b1) begin
      n_fail++;
      $display("FAIL resp_handshake: ctrl=%b required %b", obs(), 11'b1);
    end
  endtask

  task automatic test_violation();
    int last;
    int cc;
    logic exp_err;
`ifdef BDD_SBOX_CTRL_RETRY_EN
    last = 11; exp_err = 1'b0;
`else
    last = 6; exp_err = 1'b1;
`endif
    wait_ready("violation");
    in_data = 4'hA; in_valid = 1'b1; u_out = 4'b1010; c_out = 4'b0100;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= last; c++) begin
      if (c > 1) tick();
      if (c == 6) c_out = 4'b0101;
      cc = (last == 11 && c > 5) ? c - 5 : c;
      n_tests++;
      if (obs() !== exp_vec(cc, 4'hA)) begin
        n_fail++;
        $display("FAIL viol_cyc%0d: ctrl=%b required %b", c, obs(), exp_vec(cc, 4'hA));
      end
    end
    n_tests++;
    if ({out_data, out_err} !== {4'hA, exp_err}) begin
      n_fail++;
      $display("FAIL viol_result: data=%h err=%b required A/%b", out_data, out_err, exp_err);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_tests++;
    if (obs() !== 11'b1) begin
      n_fail++;
      $display("FAIL viol_handshake: ctrl=%b required %b", obs(), 11'b1);
    end
  endtask

  task automatic test_rst_eval();
    wait_ready("rst_eval");
    in_data = 4'h5; in_valid = 1'b1; u_out = 4'h5; c_out = 4'hA;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (obs() !== exp_vec(4, 4'h5)) begin
      n_fail++;
      $display("FAIL rst_eval_pre: ctrl=%b required %b", obs(), exp_vec(4, 4'h5));
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if (obs() !== 11'b0) begin
      n_fail++;
      $display("FAIL rst_eval_abort: ctrl=%b required 0", obs());
    end
    tick();
    n_tests++;
    if (obs() !== 11'b1) begin
      n_fail++;
      $display("FAIL rst_eval_idle: ctrl=%b required %b", obs(), 11'b1);
    end
  endtask

  task automatic test_rst_resp();
    wait_ready("rst_resp");
    in_data = 4'hC; in_valid = 1'b1; u_out = 4'hC; c_out = 4'h3;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 4'hC) begin
      n_fail++;
      $display("FAIL rst_resp_pre: valid=%b data=%h required 1/C", out_valid, out_data);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if (obs() !== 11'b0 || {out_data, out_err} !== 5'b0) begin
      n_fail++;
      $display("FAIL rst_resp_abort: ctrl=%b data=%h err=%b required 0", obs(), out_data, out_err);
    end
  endtask

  task automatic test_back_to_back();
    int last_acc = -1;
    int n_acc = 0;
    logic [3:0] acc_data = 4'h0;
    logic accepted;
    wait_ready("b2b");
    out_ready = 1'b1; in_valid = 1'b1; in_data = 4'h1; u_out = 4'h6; c_out = 4'h9;
    for (int cyc = 0; cyc < 46; cyc++) begin
      n_tests++;
      if ((select & selectBar) !== 4'h0) begin
        n_fail++;
        $display("FAIL b2b_rail_excl cyc%0d: sel=%h selb=%h", cyc, select, selectBar);
      end
      if (pre === 1'b1) begin
        n_tests++;
        if (select !== acc_data || selectBar !== ~acc_data) begin
          n_fail++;
          $display("FAIL b2b_select cyc%0d: sel=%h selb=%h required %h", cyc, select, selectBar, acc_data);
        end
      end
      if (out_valid === 1'b1) begin
        n_tests++;
        if ({out_data, out_err} !== {4'h6, 1'b0}) begin
          n_fail++;
          $display("FAIL b2b_result cyc%0d: data=%h err=%b required 6/0", cyc, out_data, out_err);
        end
      end
      accepted = (in_valid && in_ready);
      if (accepted) begin
        if (last_acc >= 0) begin
          n_tests++;
          if (cyc - last_acc != 7) begin
            n_fail++;
            $display("FAIL b2b_spacing: gap=%0d required 7", cyc - last_acc);
          end
        end
        last_acc = cyc;
        acc_data = in_data;
        n_acc++;
      end
      tick();
      if (accepted) in_data = in_data + 4'h3;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_tests++;
    if (n_acc != 7) begin
      n_fail++;
      $display("FAIL b2b_count: accepted=%0d required 7", n_acc);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_violation();
    test_rst_eval();
    test_rst_resp();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
